// File: rtl/trade_pkg.sv
// Shared constants and types for the trading pipeline feature and decision stages.
package trade_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_SHORT_LEN = 4;
    localparam int unsigned DEF_LONG_LEN  = 16;

    // Mean-reversion decision stage trips when |short_sma - long_sma| exceeds this.
    localparam int unsigned DEF_DECISION_THRESH = 4;

    typedef logic [DEF_DATA_W-1:0] price_t;

    // Running-sum width that holds LEN full-scale samples without wrapping.
    function automatic int unsigned SUM_W(input int unsigned len,
                                          input int unsigned data_w = DEF_DATA_W);
        return data_w + $clog2(len);
    endfunction

endpackage

// File: rtl/sma_window.sv
// One moving-average window: LEN-deep delay line, running sum and registered floor average.
module sma_window
    import trade_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN    = DEF_SHORT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg
);

    localparam int unsigned SUM_WIDTH = SUM_W(LEN, DATA_W);
    localparam int unsigned LOG2_LEN  = $clog2(LEN);

    logic [DATA_W-1:0]    line_q [LEN];
    logic [DATA_W-1:0]    line_d [LEN];
    logic [SUM_WIDTH-1:0] sum_q;
    logic [SUM_WIDTH-1:0] sum_d;
    logic [DATA_W-1:0]    avg_q;
    logic [DATA_W-1:0]    avg_d;

    // The intermediate sum may wrap, but the final value always fits, so modular math is exact.
    always_comb begin
        line_d = line_q;
        sum_d  = sum_q;
        avg_d  = avg_q;
        if (en) begin
            line_d[0] = din;
            for (int i = 1; i < int'(LEN); i++) begin
                line_d[i] = line_q[i-1];
            end
            sum_d = sum_q + SUM_WIDTH'(din) - SUM_WIDTH'(line_q[LEN-1]);
            avg_d = sum_d[SUM_WIDTH-1:LOG2_LEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '{default: '0};
            sum_q  <= '0;
            avg_q  <= '0;
        end else begin
            line_q <= line_d;
            sum_q  <= sum_d;
            avg_q  <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/sma_preprocess.sv
// Feature stage: short/long SMAs of the price stream with a strobe once the long window is full.
module sma_preprocess
    import trade_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned SHORT_LEN = DEF_SHORT_LEN,
    parameter int unsigned LONG_LEN  = DEF_LONG_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] price_in,
    input  logic              price_valid,
    output logic [DATA_W-1:0] short_sma,
    output logic [DATA_W-1:0] long_sma,
    output logic [DATA_W-1:0] current_data,
    output logic              data_valid_pre,
    output logic              warm
);

    localparam int unsigned CNT_W = $clog2(LONG_LEN + 1);

    logic              accept_c;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              warm_q;
    logic              warm_d;
    logic              dvp_q;
    logic              dvp_d;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] cur_d;

    assign accept_c = price_valid;

    sma_window #(
        .DATA_W (DATA_W),
        .LEN    (SHORT_LEN)
    ) u_short (
        .clk (clk),
        .rst (rst),
        .en  (accept_c),
        .din (price_in),
        .avg (short_sma)
    );

    sma_window #(
        .DATA_W (DATA_W),
        .LEN    (LONG_LEN)
    ) u_long (
        .clk (clk),
        .rst (rst),
        .en  (accept_c),
        .din (price_in),
        .avg (long_sma)
    );

    // Fill counter saturates at LONG_LEN; the strobe fires for every accept once full.
    always_comb begin
        cnt_d  = cnt_q;
        warm_d = warm_q;
        dvp_d  = 1'b0;
        cur_d  = cur_q;
        if (accept_c) begin
            if (cnt_q != CNT_W'(LONG_LEN)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            cur_d = price_in;
            if (cnt_d == CNT_W'(LONG_LEN)) begin
                warm_d = 1'b1;
                dvp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            warm_q <= 1'b0;
            dvp_q  <= 1'b0;
            cur_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            warm_q <= warm_d;
            dvp_q  <= dvp_d;
            cur_q  <= cur_d;
        end
    end

    assign current_data   = cur_q;
    assign data_valid_pre = dvp_q;
    assign warm           = warm_q;

endmodule

// File: tb/tb_sma_preprocess.sv
// Directed bench for sma_preprocess with hand-computed expectations and a small history model.
module tb_sma_preprocess;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] price_in = 8'd0;
    logic       price_valid = 1'b0;
    logic [7:0] short_sma;
    logic [7:0] long_sma;
    logic [7:0] current_data;
    logic       data_valid_pre;
    logic       warm;

    int n_checks = 0;
    int n_fail   = 0;
    int hist [16];
    int hcnt = 0;

    sma_preprocess #(
        .DATA_W    (8),
        .SHORT_LEN (4),
        .LONG_LEN  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .price_in       (price_in),
        .price_valid    (price_valid),
        .short_sma      (short_sma),
        .long_sma       (long_sma),
        .current_data   (current_data),
        .data_valid_pre (data_valid_pre),
        .warm           (warm)
    );

    always #5 clk = ~clk;

    function automatic int model_avg(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) s += hist[i];
        return s / len;
    endfunction

    task automatic hist_clear();
        for (int i = 0; i < 16; i++) hist[i] = 0;
        hcnt = 0;
    endtask

    task automatic push(input int v);
        price_in    = 8'(v);
        price_valid = 1'b1;
        @(posedge clk);
        #1;
        price_valid = 1'b0;
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        if (hcnt < 16) hcnt++;
    endtask

    task automatic idle();
        price_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        price_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        hist_clear();
    endtask

    task automatic test_reset();
        price_in = 8'd0;
        do_reset(2);
        n_checks++;
        if ({short_sma, long_sma, current_data, data_valid_pre, warm} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got s=%0d l=%0d c=%0d v=%0b w=%0b want all 0",
                     short_sma, long_sma, current_data, data_valid_pre, warm);
        end
    endtask

    task automatic test_warmup();
        for (int k = 1; k <= 16; k++) begin
            push(100);
            if (k == 2) begin
                n_checks++;
                if (short_sma !== 8'd50 || long_sma !== 8'd12) begin
                    n_fail++;
                    $display("FAIL fill_sums: got s=%0d l=%0d want s=50 l=12", short_sma, long_sma);
                end
            end
            if (k < 16) begin
                n_checks++;
                if (data_valid_pre !== 1'b0 || warm !== 1'b0) begin
                    n_fail++;
                    $display("FAIL warmup_no_strobe: sample %0d got v=%0b w=%0b want 0 0",
                             k, data_valid_pre, warm);
                end
            end
        end
        n_checks++;
        if (data_valid_pre !== 1'b1 || short_sma !== 8'd100 || long_sma !== 8'd100 ||
            current_data !== 8'd100 || warm !== 1'b1) begin
            n_fail++;
            $display("FAIL first_strobe: got v=%0b s=%0d l=%0d c=%0d w=%0b want 1 100 100 100 1",
                     data_valid_pre, short_sma, long_sma, current_data, warm);
        end
        idle();
        n_checks++;
        if (data_valid_pre !== 1'b0 || short_sma !== 8'd100 || current_data !== 8'd100) begin
            n_fail++;
            $display("FAIL idle_after_strobe: got v=%0b s=%0d c=%0d want 0 100 100",
                     data_valid_pre, short_sma, current_data);
        end
    endtask

    task automatic test_trend();
        push(200);
        n_checks++;
        if (data_valid_pre !== 1'b1 || short_sma !== 8'd125 || long_sma !== 8'd106) begin
            n_fail++;
            $display("FAIL trend_first: got v=%0b s=%0d l=%0d want 1 125 106",
                     data_valid_pre, short_sma, long_sma);
        end
        for (int k = 0; k < 3; k++) begin
            push(200);
            n_checks++;
            if (data_valid_pre !== 1'b1) begin
                n_fail++;
                $display("FAIL trend_back_to_back: sample %0d got v=%0b want 1", k, data_valid_pre);
            end
        end
        n_checks++;
        if (short_sma !== 8'd200 || long_sma !== 8'd125 || current_data !== 8'd200) begin
            n_fail++;
            $display("FAIL trend_final: got s=%0d l=%0d c=%0d want 200 125 200",
                     short_sma, long_sma, current_data);
        end
    endtask

    task automatic test_full_scale();
        for (int k = 0; k < 16; k++) push(255);
        n_checks++;
        if (short_sma !== 8'd255 || long_sma !== 8'd255 || data_valid_pre !== 1'b1) begin
            n_fail++;
            $display("FAIL full_scale: got s=%0d l=%0d v=%0b want 255 255 1",
                     short_sma, long_sma, data_valid_pre);
        end
        push(0);
        n_checks++;
        if (short_sma !== 8'd191 || long_sma !== 8'd239 || current_data !== 8'd0) begin
            n_fail++;
            $display("FAIL full_scale_drop: got s=%0d l=%0d c=%0d want 191 239 0",
                     short_sma, long_sma, current_data);
        end
    endtask

    task automatic test_gapped();
        int v;
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            v = (k * 37 + 11) % 256;
            push(v);
            for (int g = 0; g < 3; g++) begin
                n_checks++;
                if (short_sma !== 8'(model_avg(4)) || long_sma !== 8'(model_avg(16)) ||
                    current_data !== 8'(v) ||
                    data_valid_pre !== ((g == 0 && hcnt == 16) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL gapped: sample %0d slot %0d got s=%0d l=%0d c=%0d v=%0b want %0d %0d %0d %0b",
                             k, g, short_sma, long_sma, current_data, data_valid_pre,
                             model_avg(4), model_avg(16), v, (g == 0 && hcnt == 16));
                end
                if (g < 2) idle();
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        for (int k = 0; k < 10; k++) push(30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (warm !== 1'b0 || short_sma !== 8'd0 || long_sma !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got w=%0b s=%0d l=%0d want 0 0 0", warm, short_sma, long_sma);
        end
        rst = 1'b0;
        hist_clear();
        for (int k = 1; k <= 16; k++) begin
            push(50);
            if (k < 16) begin
                n_checks++;
                if (data_valid_pre !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_no_strobe: sample %0d got v=%0b want 0", k, data_valid_pre);
                end
            end
        end
        n_checks++;
        if (data_valid_pre !== 1'b1 || short_sma !== 8'd50 || long_sma !== 8'd50 || warm !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_strobe: got v=%0b s=%0d l=%0d w=%0b want 1 50 50 1",
                     data_valid_pre, short_sma, long_sma, warm);
        end
    endtask

    task automatic test_reset_collide();
        rst = 1'b1;
        price_in = 8'd77;
        price_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        price_valid = 1'b0;
        hist_clear();
        n_checks++;
        if ({short_sma, long_sma, current_data, data_valid_pre, warm} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_collide: got s=%0d l=%0d c=%0d v=%0b w=%0b want all 0",
                     short_sma, long_sma, current_data, data_valid_pre, warm);
        end
        push(8);
        n_checks++;
        if (short_sma !== 8'd2 || long_sma !== 8'd0 || current_data !== 8'd8 || data_valid_pre !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_collide_discard: got s=%0d l=%0d c=%0d v=%0b want 2 0 8 0",
                     short_sma, long_sma, current_data, data_valid_pre);
        end
    endtask

    initial begin
        hist_clear();
        test_reset();
        test_warmup();
        test_trend();
        test_full_scale();
        test_gapped();
        test_reset_mid();
        test_reset_collide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
